// File: rtl/decode_stage_if.sv
// Fetch-side, hazard-control, write-back and decode-output signals of the Y86-64 decode stage.
// The decode stage attaches through the slave modport; the driver of those signals uses master.
interface decode_stage_if;
    logic [3:0]  f_icode_i;
    logic [3:0]  f_ifun_i;
    logic [3:0]  f_rA_i;
    logic [3:0]  f_rB_i;
    logic [63:0] f_valC_i;
    logic [63:0] f_valP_i;
    logic        f_instr_valid_i;
    logic        f_imem_error_i;
    logic        d_stall_i;
    logic        d_bubble_i;
    logic [3:0]  w_dstE_i;
    logic [63:0] w_valE_i;
    logic [3:0]  w_dstM_i;
    logic [63:0] w_valM_i;
    logic [2:0]  d_stat_o;
    logic [3:0]  d_icode_o;
    logic [3:0]  d_ifun_o;
    logic [63:0] d_valC_o;
    logic [63:0] d_valA_o;
    logic [63:0] d_valB_o;
    logic [3:0]  d_srcA_o;
    logic [3:0]  d_srcB_o;
    logic [3:0]  d_dstE_o;
    logic [3:0]  d_dstM_o;

    modport slave (
        input  f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_valC_i, f_valP_i,
               f_instr_valid_i, f_imem_error_i, d_stall_i, d_bubble_i,
               w_dstE_i, w_valE_i, w_dstM_i, w_valM_i,
        output d_stat_o, d_icode_o, d_ifun_o, d_valC_o, d_valA_o, d_valB_o,
               d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o
    );

    modport master (
        output f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_valC_i, f_valP_i,
               f_instr_valid_i, f_imem_error_i, d_stall_i, d_bubble_i,
               w_dstE_i, w_valE_i, w_dstM_i, w_valM_i,
        input  d_stat_o, d_icode_o, d_ifun_o, d_valC_o, d_valA_o, d_valB_o,
               d_srcA_o, d_srcB_o, d_dstE_o, d_dstM_o
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F->D pipeline register, register-select decode, and a 15x64
// register file with two write-back ports and same-cycle write-through on the read path.
module decode_stage #(
    parameter logic [3:0] HALT_ICODE = 4'h0,
    parameter logic [3:0] NOP_ICODE  = 4'h1,
    parameter logic [3:0] RSP_IDX    = 4'h4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    decode_stage_if.slave dif
);
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    stat_e       d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [3:0]  d_rA;
    logic [3:0]  d_rB;
    logic [63:0] d_valC;
    logic [63:0] d_valP;

    logic [63:0] regs [15];

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] stored_a, stored_b, read_a, read_b;

    always_ff @(posedge clk_i) begin
        if (rst_i || (!dif.d_stall_i && dif.d_bubble_i)) begin
            d_stat  <= STAT_AOK;
            d_icode <= NOP_ICODE;
            d_ifun  <= '0;
            d_rA    <= REG_NONE;
            d_rB    <= REG_NONE;
            d_valC  <= '0;
            d_valP  <= '0;
        end else if (!dif.d_stall_i) begin
            if (dif.f_imem_error_i)            d_stat <= STAT_ADR;
            else if (!dif.f_instr_valid_i)     d_stat <= STAT_INS;
            else if (dif.f_icode_i == HALT_ICODE) d_stat <= STAT_HLT;
            else                               d_stat <= STAT_AOK;
            d_icode <= dif.f_icode_i;
            d_ifun  <= dif.f_ifun_i;
            d_rA    <= dif.f_rA_i;
            d_rB    <= dif.f_rB_i;
            d_valC  <= dif.f_valC_i;
            d_valP  <= dif.f_valP_i;
        end
    end

    // M port is tested first so it wins when both ports target the same register.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < 15; i++) begin
            if (rst_i)                         regs[i] <= '0;
            else if (dif.w_dstM_i == 4'(i))    regs[i] <= dif.w_valM_i;
            else if (dif.w_dstE_i == 4'(i))    regs[i] <= dif.w_valE_i;
        end
    end

    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        if (d_stat == STAT_AOK) begin
            case (d_icode)
                4'h2: begin src_a = d_rA; dst_e = d_rB; end
                4'h3: dst_e = d_rB;
                4'h4: begin src_a = d_rA; src_b = d_rB; end
                4'h5: begin src_b = d_rB; dst_m = d_rA; end
                4'h6: begin src_a = d_rA; src_b = d_rB; dst_e = d_rB; end
                4'h8: begin src_b = RSP_IDX; dst_e = RSP_IDX; end
                4'h9: begin src_a = RSP_IDX; src_b = RSP_IDX; dst_e = RSP_IDX; end
                4'hA: begin src_a = d_rA; src_b = RSP_IDX; dst_e = RSP_IDX; end
                4'hB: begin src_a = RSP_IDX; src_b = RSP_IDX; dst_e = RSP_IDX; dst_m = d_rA; end
                default: ;
            endcase
        end
    end

    function automatic logic [63:0] rf_read(input logic [3:0] idx, input logic [63:0] stored,
                                            input logic [3:0] w_e, input logic [63:0] v_e,
                                            input logic [3:0] w_m, input logic [63:0] v_m);
        if (idx == REG_NONE) return '0;
        if (idx == w_m)      return v_m;
        if (idx == w_e)      return v_e;
        return stored;
    endfunction

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        if (src_a != REG_NONE) stored_a = regs[src_a];
        if (src_b != REG_NONE) stored_b = regs[src_b];
        read_a = rf_read(src_a, stored_a, dif.w_dstE_i, dif.w_valE_i, dif.w_dstM_i, dif.w_valM_i);
        read_b = rf_read(src_b, stored_b, dif.w_dstE_i, dif.w_valE_i, dif.w_dstM_i, dif.w_valM_i);
    end

    assign dif.d_stat_o  = d_stat;
    assign dif.d_icode_o = d_icode;
    assign dif.d_ifun_o  = d_ifun;
    assign dif.d_valC_o  = d_valC;
    assign dif.d_valA_o  = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valP : read_a;
    assign dif.d_valB_o  = read_b;
    assign dif.d_srcA_o  = src_a;
    assign dif.d_srcB_o  = src_b;
    assign dif.d_dstE_o  = dst_e;
    assign dif.d_dstM_o  = dst_m;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a per-cycle compare against an instruction-level model
// of the D register and register file, plus literal checks that pin the model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if dif();

    decode_stage #(.HALT_ICODE(4'h0), .NOP_ICODE(4'h1), .RSP_IDX(4'h4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .dif   (dif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [3:0]  m_icode, m_ifun, m_rA, m_rB;
    logic [63:0] m_valC, m_valP;
    logic [2:0]  m_stat;
    logic [63:0] m_regs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] e_srcA();
        if (m_stat != 3'd1) return 4'hF;
        if (m_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return m_rA;
        if (m_icode inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] e_srcB();
        if (m_stat != 3'd1) return 4'hF;
        if (m_icode inside {4'h4, 4'h5, 4'h6}) return m_rB;
        if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] e_dstE();
        if (m_stat != 3'd1) return 4'hF;
        if (m_icode inside {4'h2, 4'h3, 4'h6}) return m_rB;
        if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] e_dstM();
        if (m_stat != 3'd1) return 4'hF;
        if (m_icode inside {4'h5, 4'hB}) return m_rA;
        return 4'hF;
    endfunction

    function automatic logic [63:0] e_read(input logic [3:0] idx);
        if (idx == 4'hF) return 64'd0;
        if (idx == dif.w_dstM_i) return dif.w_valM_i;
        if (idx == dif.w_dstE_i) return dif.w_valE_i;
        return m_regs[idx];
    endfunction

    // Model of one rising edge, from the inputs as they stand at that edge.
    task automatic model_edge();
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 64'd0;
        end else begin
            if (dif.w_dstE_i != 4'hF) m_regs[dif.w_dstE_i] = dif.w_valE_i;
            if (dif.w_dstM_i != 4'hF) m_regs[dif.w_dstM_i] = dif.w_valM_i;
        end
        if (rst || (!dif.d_stall_i && dif.d_bubble_i)) begin
            m_icode = 4'h1; m_ifun = 4'h0; m_rA = 4'hF; m_rB = 4'hF;
            m_valC = 64'd0; m_valP = 64'd0; m_stat = 3'd1;
        end else if (!dif.d_stall_i) begin
            m_icode = dif.f_icode_i; m_ifun = dif.f_ifun_i;
            m_rA = dif.f_rA_i; m_rB = dif.f_rB_i;
            m_valC = dif.f_valC_i; m_valP = dif.f_valP_i;
            m_stat = dif.f_imem_error_i ? 3'd3 : !dif.f_instr_valid_i ? 3'd4 :
                     (dif.f_icode_i == 4'h0) ? 3'd2 : 3'd1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stat",  dif.d_stat_o,  m_stat);
            check("icode", dif.d_icode_o, m_icode);
            check("ifun",  dif.d_ifun_o,  m_ifun);
            check("valC",  dif.d_valC_o,  m_valC);
            check("srcA",  dif.d_srcA_o,  e_srcA());
            check("srcB",  dif.d_srcB_o,  e_srcB());
            check("dstE",  dif.d_dstE_o,  e_dstE());
            check("dstM",  dif.d_dstM_o,  e_dstM());
            check("valA",  dif.d_valA_o,
                  (m_icode == 4'h7 || m_icode == 4'h8) ? m_valP : e_read(e_srcA()));
            check("valB",  dif.d_valB_o,  e_read(e_srcB()));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] valc, input logic [63:0] valp);
        dif.f_icode_i = icode; dif.f_ifun_i = ifun; dif.f_rA_i = ra; dif.f_rB_i = rb;
        dif.f_valC_i = valc; dif.f_valP_i = valp;
        dif.f_instr_valid_i = 1'b1; dif.f_imem_error_i = 1'b0;
    endtask

    task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm,
                      input logic [63:0] vm);
        dif.w_dstE_i = de; dif.w_valE_i = ve; dif.w_dstM_i = dm; dif.w_valM_i = vm;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_icode"}, dif.d_icode_o, 4'h1);
        check({tag, "_stat"},  dif.d_stat_o,  3'd1);
        check({tag, "_srcA"},  dif.d_srcA_o,  4'hF);
        check({tag, "_srcB"},  dif.d_srcB_o,  4'hF);
        check({tag, "_dstE"},  dif.d_dstE_o,  4'hF);
        check({tag, "_dstM"},  dif.d_dstM_o,  4'hF);
        check({tag, "_valA"},  dif.d_valA_o,  64'd0);
        check({tag, "_valB"},  dif.d_valB_o,  64'd0);
    endtask

    initial begin
        fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        wb(4'hF, 64'd0, 4'hF, 64'd0);
        dif.d_stall_i = 1'b0; dif.d_bubble_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check_idle("rst");

        rst = 1'b1; dif.d_stall_i = 1'b1;
        tick();
        rst = 1'b0; dif.d_stall_i = 1'b0;
        check_idle("rst_stall");

        // Write r5/r6 then OPq rA=5 rB=6
        wb(4'h5, 64'h11, 4'h6, 64'h22);
        tick();
        wb(4'hF, 64'd0, 4'hF, 64'd0);
        fetch(4'h6, 4'h1, 4'h5, 4'h6, 64'd0, 64'h2);
        tick();
        check("opq_srcA", dif.d_srcA_o, 4'h5);
        check("opq_srcB", dif.d_srcB_o, 4'h6);
        check("opq_dstE", dif.d_dstE_o, 4'h6);
        check("opq_dstM", dif.d_dstM_o, 4'hF);
        check("opq_valA", dif.d_valA_o, 64'h11);
        check("opq_valB", dif.d_valB_o, 64'h22);

        // Bypass: both write ports hit r3 while D holds rrmovq rA=3
        fetch(4'h2, 4'h0, 4'h3, 4'h1, 64'd0, 64'h4);
        tick();
        dif.d_stall_i = 1'b1;
        wb(4'h3, 64'hAA, 4'h3, 64'hBB);
        #1;
        check("byp_valA_comb", dif.d_valA_o, 64'hBB);
        tick();
        wb(4'hF, 64'd0, 4'hF, 64'd0);
        #1;
        check("byp_valA_reg", dif.d_valA_o, 64'hBB);
        dif.d_stall_i = 1'b0;

        // Stack operations
        fetch(4'hA, 4'h0, 4'h2, 4'hF, 64'd0, 64'h12);
        tick();
        check("push_srcA", dif.d_srcA_o, 4'h2);
        check("push_srcB", dif.d_srcB_o, 4'h4);
        check("push_dstE", dif.d_dstE_o, 4'h4);
        fetch(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h20);
        tick();
        check("call_valA", dif.d_valA_o, 64'h20);
        check("call_srcB", dif.d_srcB_o, 4'h4);
        check("call_dstE", dif.d_dstE_o, 4'h4);
        fetch(4'hB, 4'h0, 4'h7, 4'hF, 64'd0, 64'h22);
        tick();
        check("pop_srcA", dif.d_srcA_o, 4'h4);
        check("pop_srcB", dif.d_srcB_o, 4'h4);
        check("pop_dstE", dif.d_dstE_o, 4'h4);
        check("pop_dstM", dif.d_dstM_o, 4'h7);

        // Status encodings
        fetch(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
        dif.f_imem_error_i = 1'b1;
        tick();
        check("adr_stat", dif.d_stat_o, 3'd3);
        check("adr_srcA", dif.d_srcA_o, 4'hF);
        check("adr_srcB", dif.d_srcB_o, 4'hF);
        check("adr_dstE", dif.d_dstE_o, 4'hF);
        fetch(4'hE, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
        dif.f_instr_valid_i = 1'b0;
        tick();
        check("ins_stat", dif.d_stat_o, 3'd4);
        fetch(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        tick();
        check("hlt_stat", dif.d_stat_o, 3'd2);

        // Stall and bubble
        fetch(4'h3, 4'h0, 4'hF, 4'h5, 64'h0123456789ABCDEF, 64'h0A);
        tick();
        check("irm_dstE", dif.d_dstE_o, 4'h5);
        check("irm_valC", dif.d_valC_o, 64'h0123456789ABCDEF);
        fetch(4'h6, 4'h3, 4'h1, 4'h2, 64'h5555, 64'h0C);
        dif.d_stall_i = 1'b1;
        tick();
        check("stall_dstE", dif.d_dstE_o, 4'h5);
        check("stall_valC", dif.d_valC_o, 64'h0123456789ABCDEF);
        dif.d_stall_i = 1'b0; dif.d_bubble_i = 1'b1;
        tick();
        check("bub_icode", dif.d_icode_o, 4'h1);
        check("bub_dstE",  dif.d_dstE_o,  4'hF);
        dif.d_bubble_i = 1'b0;
        fetch(4'h3, 4'h0, 4'hF, 4'h5, 64'h0123456789ABCDEF, 64'h0A);
        tick();
        fetch(4'h6, 4'h3, 4'h1, 4'h2, 64'h5555, 64'h0C);
        dif.d_stall_i = 1'b1; dif.d_bubble_i = 1'b1;
        tick();
        check("sb_icode", dif.d_icode_o, 4'h3);
        check("sb_dstE",  dif.d_dstE_o,  4'h5);
        dif.d_stall_i = 1'b0; dif.d_bubble_i = 1'b0;

        // Reset overrides a pending write to r3
        rst = 1'b1;
        wb(4'hF, 64'd0, 4'h3, 64'h55);
        tick();
        rst = 1'b0;
        wb(4'hF, 64'd0, 4'hF, 64'd0);
        fetch(4'h2, 4'h0, 4'h3, 4'h1, 64'd0, 64'h2);
        tick();
        check("rstwr_valA", dif.d_valA_o, 64'd0);
        check("rstwr_dstE", dif.d_dstE_o, 4'h1);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 decode stage, directly downstream of fetchC.
- Holds the F→D pipeline register, which captures fetchC outputs each cycle.
- Decodes register selects (srcA, srcB, dstE, dstM) per instruction class.
- Owns the 15×64 register file, with two synchronous write-back ports (E, M) and a combinational read path with write-back bypass; feeds execute with valA/valB/valC.

Parameters:
- HALT_ICODE, 4'h0, icode decoded as halt (sets stat HLT); icode 4'h1 is nop.
- NOP_ICODE, 4'h1, icode inserted on bubble.
- RSP_IDX, 4'h4, register index of %rsp.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- f_icode_i  in  4  from fetchC icode_o.
- f_ifun_i  in  4  from fetchC ifun_o.
- f_rA_i  in  4  from fetchC rA_o.
- f_rB_i  in  4  from fetchC rB_o.
- f_valC_i  in  64  from fetchC valC_o.
- f_valP_i  in  64  from fetchC valP_o.
- f_instr_valid_i  in  1  from fetchC instr_valid_o.
- f_imem_error_i  in  1  from fetchC imem_error_o.
- d_stall_i  in  1  hold the D register.
- d_bubble_i  in  1  load a bubble into the D register.
- w_dstE_i  in  4  write-back E index; F = no write.
- w_valE_i  in  64  write-back E data.
- w_dstM_i  in  4  write-back M index; F = no write.
- w_valM_i  in  64  write-back M data.
- d_stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- d_icode_o  out  4  registered icode.
- d_ifun_o  out  4  registered ifun.
- d_valC_o  out  64  registered valC.
- d_valA_o  out  64  operand A.
- d_valB_o  out  64  operand B.
- d_srcA_o  out  4  decoded source A.
- d_srcB_o  out  4  decoded source B.
- d_dstE_o  out  4  decoded destination E.
- d_dstM_o  out  4  decoded destination M.

Behaviour:
- Reset and clocking: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset state:
  - D register holds a bubble: icode=NOP_ICODE, ifun=0, rA=rB=F, valC=valP=0, stat=AOK.
  - All 15 registers = 0.
  - Resulting outputs: d_dstE/dstM/srcA/srcB = F, d_valA = d_valB = 0.
  - Reset overrides writes, stall and bubble in the same cycle.
- D register update (rising edge, priority order):
  1. rst_i
  2. d_stall_i: hold all fields. Stall wins over bubble if both are asserted.
  3. d_bubble_i: load the bubble value.
  4. Otherwise: capture the f_* inputs.
- Status on capture (priority order):
  - f_imem_error_i → ADR.
  - else !f_instr_valid_i → INS.
  - else f_icode_i==HALT_ICODE → HLT.
  - else AOK.
- Latency: fetch→D outputs is 1 cycle. All decode logic after the register is combinational.
- srcA:
  - rA for icode 2, 4, 6, A.
  - RSP_IDX for 9, B.
  - else F.
- srcB:
  - rB for icode 4, 5, 6.
  - RSP_IDX for 8, 9, A, B.
  - else F.
- dstE:
  - rB for icode 2, 3, 6. cmov ifun is passed through; the condition is resolved in execute.
  - RSP_IDX for 8, 9, A, B.
  - else F.
- dstM:
  - rA for icode 5, B.
  - else F.
- When stat≠AOK, all four selects are forced to F.
- Register file:
  - Indices 0–14; index F reads 0 and is never written.
  - Writes occur at the rising edge when the index ≠ F.
  - If w_dstE_i == w_dstM_i ≠ F, the M write wins.
- Read path, evaluated in order:
  1. index==F → 0.
  2. index==w_dstM_i → w_valM_i.
  3. index==w_dstE_i → w_valE_i.
  4. Otherwise the stored register value.
  - This is same-cycle write-through.
- d_valA_o: the registered valP for icode 7 (jXX) and 8 (call); otherwise the srcA read.
- d_valB_o: the srcB read.
- Widths: no arithmetic performed. All 64-bit values pass unmodified.

Test Plan:
- Reset then idle: after rst_i is held 1 cycle → d_icode=1, d_stat=1, srcA/srcB/dstE/dstM=F, valA=valB=0; repeat with d_stall_i=1 during reset → same result.
- Write then OPq:
  - Stimulus: w_dstE=5, w_valE=0x11 and w_dstM=6, w_valM=0x22 for 1 cycle; then capture fetch {icode=6, ifun=1, rA=5, rB=6}.
  - Required next cycle: srcA=5, srcB=6, dstE=6, dstM=F, valA=0x11, valB=0x22.
- Bypass priority:
  - Stimulus: D holds rrmovq rA=3; in the same cycle w_dstE=3, w_valE=0xAA and w_dstM=3, w_valM=0xBB.
  - Required: valA=0xBB combinationally; register 3 reads 0xBB after the edge.
- Stack ops:
  - pushq rA=2: srcA=2, srcB=4, dstE=4.
  - call valP=0x20: valA=0x20, srcB=4, dstE=4.
  - popq rA=7: srcA=4, srcB=4, dstE=4, dstM=7.
- Status:
  - f_imem_error=1 → stat=3, all selects F.
  - f_instr_valid=0, icode=E → stat=4.
  - icode=0 → stat=2.
- Stall/bubble:
  - Capture irmovq valC=0x0123456789ABCDEF, rB=5.
  - Next cycle: stall=1 with new fetch data → outputs unchanged (dstE=5, valC held).
  - Then bubble=1 → icode=1, dstE=F.
  - stall=bubble=1 → hold.
